muldiv_scheduler: RTL and testbench
===================================

# muldiv_scheduler

Shared iterative multiply/divide engine with a round-robin scheduler that serves the execute stages of up to NUM_REQ cores. An execute stage that decodes an RV32M operation raises a request, stalls until its response pulse arrives, and cancels the request on a pipeline flush. The block has one radix-2 shift-add multiplier / restoring divider datapath. It sequences that datapath through a fixed state machine and returns each result to the requester that owns the operation.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting execute stages (2..8)
- XLEN, DATA_SIZE (32), operand/result width

Ports:
- i_aclk  in  1  clock
- i_areset_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  NUM_REQ  per-requester request; held until accepted or flushed
- o_req_ready  out  NUM_REQ  one-hot accept; handshake = valid & ready at a rising edge
- i_req_op  in  NUM_REQ x 3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- i_req_a  in  NUM_REQ x XLEN  rs1 operand (forwarded value)
- i_req_b  in  NUM_REQ x XLEN  rs2 operand
- i_flush  in  NUM_REQ  per-requester cancel (branch/JALR redirect)
- o_rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owner
- o_rsp_data  out  XLEN  result; valid only while o_rsp_valid is nonzero
- o_busy  out  1  engine not IDLE

## Operation
- States: IDLE, PREP, CALC, FIX, RESP.
- IDLE:
  - o_req_ready is asserted combinationally to the first valid, unflushed requester after rr_ptr (round-robin).
  - On handshake: latch owner, op, a, b; rr_ptr <= owner; go to PREP.
- PREP:
  - Compute operand magnitudes and the result sign. Signedness per op: MULHSU treats a as signed and b as unsigned.
  - Load accumulator/remainder = 0 and cnt = XLEN-1; go to CALC.
- CALC, one iteration per cycle:
  - Multiply: if multiplier LSB is set, add the multiplicand into a 2*XLEN product, then shift right.
  - Divide: shift {rem, quot} left by 1, trial-subtract the divisor from rem, set the quotient bit if rem >= divisor.
  - At cnt==0 go to FIX; otherwise cnt decrements.
- FIX:
  - Apply two's-complement sign correction.
  - MUL selects the low word; MULH/MULHSU/MULHU select the high word.
  - Remainder takes the sign of the dividend.
  - Register the result in o_rsp_data; go to RESP.
- RESP: o_rsp_valid[owner]=1 for one cycle; go to IDLE. No new grant is issued in the RESP cycle.
- Architectural special cases:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - DIV 0x80000000 / -1 gives 0x80000000; REM gives 0.
- Flush:
  - i_flush[owner] in PREP/CALC/FIX: go to IDLE at the next edge with no response.
  - i_flush[owner] in RESP: masks o_rsp_valid in that cycle.
  - Flush of a non-owner has no effect on the engine. It does suppress that requester's o_req_ready in the same cycle.
- Reset values:
  - state=IDLE, o_rsp_valid=0, o_rsp_data=0, o_busy=0, o_req_ready=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-operation discards the operation silently.

## Timing
- Latency from the accepting edge E0:
  - PREP after E0.
  - CALC for XLEN cycles, E1..E32.
  - FIX after E33.
  - o_rsp_valid high in the cycle after E34.
  - Total 35 cycles; throughput 1 op / 36 cycles.
- Early-out (macro on): PREP goes directly to FIX, giving o_rsp_valid in the cycle after E2.
- o_req_ready is combinational from i_req_valid, i_flush, state and rr_ptr. All other outputs are registered.
- Simultaneous requests are served in round-robin order starting from rr_ptr+1 (mod NUM_REQ), wrapping at NUM_REQ-1 -> 0.
- A requester whose request is accepted in the same cycle its i_flush is asserted is never granted.

## Configuration
- MULDIV_EARLY_OUT_EN, defined: the following are detected in PREP and skip CALC (3-cycle latency):
  - divide by zero
  - signed overflow
  - either multiply operand zero
- MULDIV_EARLY_OUT_EN, undefined: every operation takes the full 35-cycle latency.
- Results are bit-identical in both builds.

## Test plan
- Req 0, MUL a=7, b=-3 -> o_rsp_valid[0] after 35 cycles, data 0xFFFFFFEB.
- Req 2, MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REM 0x80000000/-1 -> 0. With the macro, the /0 and overflow cases complete in 3 cycles.
- Requests 0, 1, 3 held valid continuously from reset -> grants in order 0, 1, 3, 0. No o_req_ready while o_busy=1.
- Owner 1 accepted, i_flush[1] pulsed at CALC cycle 10 -> engine back to IDLE next edge, no o_rsp_valid. A pending request 2 is granted in that IDLE cycle.
- i_areset_n dropped during CALC -> all outputs 0 immediately. First grant after release goes to requester 0.

Source files
------------

// File: rtl/muldiv_scheduler.sv
// Shared radix-2 multiply/restoring-divide engine with a round-robin front end for NUM_REQ execute stages.
// Optional MULDIV_EARLY_OUT_EN: zero/overflow/div-by-zero cases skip CALC and go straight to FIX.
module muldiv_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int XLEN    = 32
) (
    input  logic                           i_aclk,
    input  logic                           i_areset_n,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic [NUM_REQ-1:0][2:0]        i_req_op,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   i_req_a,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   i_req_b,
    input  logic [NUM_REQ-1:0]             i_flush,
    output logic [NUM_REQ-1:0]             o_rsp_valid,
    output logic [XLEN-1:0]                o_rsp_data,
    output logic                           o_busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_RESP} state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       rr_ptr, owner_q, gnt_idx;
    logic                gnt_any;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q, b_q, md;
    logic [2*XLEN-1:0]   prod;
    logic [CW-1:0]       cnt;
    logic                neg_q, rsp_vld_q;

    // Round-robin search starting just after the last owner; flushed requesters are skipped.
    always_comb begin
        int j;
        j       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (!gnt_any && i_req_valid[j] && !i_flush[j]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

    logic handshake;
    assign handshake = (state == S_IDLE) && gnt_any;

    always_comb begin
        o_req_ready = '0;
        if (handshake && i_areset_n) o_req_ready[gnt_idx] = 1'b1;
    end

    // Operation decode and operand conditioning from the latched request.
    logic is_div, is_rem, sgn_a, sgn_b, a_neg, b_neg;
    logic div_zero, div_ovf, mul_zero, early;
    logic [XLEN-1:0] mag_a, mag_b;

    assign is_div   = op_q[2];
    assign is_rem   = op_q[2] & op_q[1];
    assign sgn_a    = is_div ? !op_q[0] : (op_q != 3'd3);
    assign sgn_b    = is_div ? !op_q[0] : (op_q[2:1] == 2'b00);
    assign a_neg    = sgn_a & a_q[XLEN-1];
    assign b_neg    = sgn_b & b_q[XLEN-1];
    assign mag_a    = a_neg ? -a_q : a_q;
    assign mag_b    = b_neg ? -b_q : b_q;
    assign div_zero = is_div && (b_q == '0);
    assign div_ovf  = is_div && !op_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    assign mul_zero = !is_div && ((a_q == '0) || (b_q == '0));

`ifdef MULDIV_EARLY_OUT_EN
    assign early = div_zero | div_ovf | mul_zero;
`else
    assign early = 1'b0;
`endif

    logic owner_flush;
    assign owner_flush = i_flush[owner_q];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (gnt_any) state_nxt = S_PREP;
            S_PREP: state_nxt = owner_flush ? S_IDLE : (early ? S_FIX : S_CALC);
            S_CALC: if (owner_flush) state_nxt = S_IDLE;
                    else if (cnt == '0) state_nxt = S_FIX;
            S_FIX:  state_nxt = owner_flush ? S_IDLE : S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One datapath iteration: prod holds {acc, multiplier} or {rem, quot}.
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] step;
    always_comb begin
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, md} : '0);
        div_sh   = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
        div_diff = div_sh - {1'b0, md};
        div_ge   = div_sh >= {1'b0, md};
        if (is_div)
            step = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), prod[XLEN-2:0], div_ge};
        else
            step = {mul_sum, prod[XLEN-1:1]};
    end

    // Sign correction, word select and architectural special cases.
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, result;
    always_comb begin
        prod_s = neg_q ? -prod : prod;
        quot_s = neg_q ? -prod[XLEN-1:0] : prod[XLEN-1:0];
        rem_s  = neg_q ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
        if (div_zero)      result = is_rem ? a_q : '1;
        else if (div_ovf)  result = is_rem ? '0 : a_q;
        else if (mul_zero) result = '0;
        else if (is_div)   result = is_rem ? rem_s : quot_s;
        else               result = (op_q == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state      <= S_IDLE;
            rr_ptr     <= IW'(NUM_REQ-1);
            owner_q    <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            md         <= '0;
            prod       <= '0;
            cnt        <= '0;
            neg_q      <= 1'b0;
            rsp_vld_q  <= 1'b0;
            o_rsp_data <= '0;
        end else begin
            state     <= state_nxt;
            rsp_vld_q <= (state == S_FIX) && !owner_flush;
            if (handshake) begin
                owner_q <= gnt_idx;
                rr_ptr  <= gnt_idx;
                op_q    <= i_req_op[gnt_idx];
                a_q     <= i_req_a[gnt_idx];
                b_q     <= i_req_b[gnt_idx];
            end
            if (state == S_PREP) begin
                prod  <= {{XLEN{1'b0}}, mag_a};
                md    <= mag_b;
                cnt   <= CW'(XLEN-1);
                neg_q <= is_rem ? a_neg : (a_neg ^ b_neg);
            end
            if (state == S_CALC) begin
                prod <= step;
                cnt  <= cnt - 1'b1;
            end
            if (state == S_FIX && !owner_flush) o_rsp_data <= result;
        end
    end

    // A flush landing in the RESP cycle kills the pulse to its owner.
    always_comb begin
        o_rsp_valid = '0;
        if (rsp_vld_q) o_rsp_valid[owner_q] = !i_flush[owner_q];
    end

    assign o_busy = (state != S_IDLE);
endmodule

// File: tb/tb_muldiv_scheduler.sv
// Self-checking bench for muldiv_scheduler: directed RV32M cases, randomized ops vs. arithmetic model,
// round-robin order, flush behaviour and asynchronous reset.
module tb_muldiv_scheduler;
    localparam int N = 4;
    localparam int X = 32;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [N-1:0]         valid, ready, flush, rsp_valid;
    logic [N-1:0][2:0]    op;
    logic [N-1:0][X-1:0]  a, b;
    logic [X-1:0]         rsp_data;
    logic                 busy;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muldiv_scheduler #(.NUM_REQ(N), .XLEN(X)) dut (
        .i_aclk(clk), .i_areset_n(rstn),
        .i_req_valid(valid), .o_req_ready(ready),
        .i_req_op(op), .i_req_a(a), .i_req_b(b),
        .i_flush(flush), .o_rsp_valid(rsp_valid),
        .o_rsp_data(rsp_data), .o_busy(busy)
    );

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, p;
        logic ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'b0, x};
        uy  = {32'b0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        p   = 0;
        case (f)
            3'd0: begin p = sx * sy; return p[31:0];  end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin if (y == 0) return 32'hFFFF_FFFF; if (ovf) return x; p = sx / sy; return p[31:0]; end
            3'd5: begin if (y == 0) return 32'hFFFF_FFFF; p = ux / uy; return p[31:0]; end
            3'd6: begin if (y == 0) return x; if (ovf) return 32'h0; p = sx % sy; return p[31:0]; end
            default: begin if (y == 0) return x; p = ux % uy; return p[31:0]; end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
        if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 3;
        if (!f[2] && (x == 0 || y == 0)) return 3;
`endif
        return 35;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] c [4];
        c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'hFFFF_FFFF; c[3] = 32'h8000_0000;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    // Issue one op from requester r and wait for its response; ok=0 on timeout.
    task automatic run_op(input int r, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] d, output int lat, output bit ok);
        bit g;
        g = 0; ok = 0; d = '0; lat = 0;
        @(negedge clk);
        valid[r] = 1'b1; op[r] = f; a[r] = x; b[r] = y;
        for (int i = 0; i < 300 && !g; i++) begin
            #1;
            if (ready[r]) g = 1;
            else @(negedge clk);
        end
        if (!g) begin valid[r] = 1'b0; return; end
        @(posedge clk); #1 valid[r] = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (rsp_valid[r]) begin lat = i; d = rsp_data; ok = 1; break; end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; valid = '1; flush = '0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (ready !== '0)     begin fails++; $display("FAIL reset_ready got=%b want=0", ready); end
        tests++; if (rsp_valid !== '0) begin fails++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        tests++; if (rsp_data !== '0)  begin fails++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
        valid = '0;
        @(negedge clk); rstn = 1'b1;
    endtask

    task automatic test_directed();
        int          rq [9] = '{0, 2, 2, 1, 1, 3, 3, 0, 0};
        logic [2:0]  fo [9] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd6, 3'd4, 3'd7};
        logic [31:0] xa [9] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5};
        logic [31:0] yb [9] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ex [9] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'd5};
        logic [31:0] d;
        int lat;
        bit ok;
        for (int i = 0; i < 9; i++) begin
            run_op(rq[i], fo[i], xa[i], yb[i], d, lat, ok);
            tests++;
            if (!ok || d !== ex[i]) begin
                fails++; $display("FAIL directed[%0d]_data got=%h ok=%0d want=%h", i, d, ok, ex[i]);
            end
            tests++;
            if (lat != exp_lat(fo[i], xa[i], yb[i])) begin
                fails++; $display("FAIL directed[%0d]_latency got=%0d want=%0d", i, lat, exp_lat(fo[i], xa[i], yb[i]));
            end
            @(negedge clk);
            tests++;
            if (rsp_valid !== '0) begin fails++; $display("FAIL directed[%0d]_pulse got=%b want=0", i, rsp_valid); end
        end
    endtask

    task automatic test_random();
        logic [31:0] d, x, y;
        logic [2:0]  f;
        int r, lat;
        bit ok;
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, N-1);
            f = 3'($urandom_range(0, 7));
            x = pick();
            y = pick();
            run_op(r, f, x, y, d, lat, ok);
            tests++;
            if (!ok || d !== model(f, x, y)) begin
                fails++; $display("FAIL random[%0d]_data op=%0d a=%h b=%h got=%h want=%h", i, f, x, y, d, model(f, x, y));
            end
            tests++;
            if (lat != exp_lat(f, x, y)) begin
                fails++; $display("FAIL random[%0d]_latency got=%0d want=%0d", i, lat, exp_lat(f, x, y));
            end
        end
    endtask

    task automatic test_round_robin();
        int want [4] = '{0, 1, 3, 0};
        int got  [4] = '{-1, -1, -1, -1};
        int n = 0, viol = 0;
        @(negedge clk); rstn = 1'b0;
        for (int k = 0; k < N; k++) begin op[k] = 3'd0; a[k] = 32'd3; b[k] = 32'd5; end
        valid = 4'b1011;
        @(negedge clk); rstn = 1'b1;
        for (int c = 0; c < 400 && n < 4; c++) begin
            #1;
            if (busy && ready !== '0) viol++;
            if (ready !== '0) begin
                if (!$onehot(ready)) viol++;
                for (int k = 0; k < N; k++) if (ready[k]) got[n] = k;
                n++;
            end
            @(negedge clk);
        end
        valid = '0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (got[k] != want[k]) begin fails++; $display("FAIL rr_grant[%0d] got=%0d want=%0d", k, got[k], want[k]); end
        end
        tests++;
        if (viol != 0) begin fails++; $display("FAIL rr_ready_while_busy got=%0d want=0", viol); end
        wait_idle();
    endtask

    task automatic test_flush();
        logic [31:0] d;
        int lat = 0;
        bit seen1 = 0, g = 0;
        // non-owner flush suppresses that requester's ready
        @(negedge clk);
        valid[3] = 1'b1; flush[3] = 1'b1; op[3] = 3'd0; a[3] = 32'd1; b[3] = 32'd1;
        #1;
        tests++; if (ready !== '0) begin fails++; $display("FAIL flush_ready_suppress got=%b want=0", ready); end
        flush[3] = 1'b0; #1;
        tests++; if (ready !== 4'b1000) begin fails++; $display("FAIL flush_ready_restore got=%b want=1000", ready); end
        valid[3] = 1'b0;
        // owner 1 flushed in CALC; pending request 2 granted in the next IDLE cycle
        @(negedge clk);
        valid[1] = 1'b1; op[1] = 3'd0; a[1] = 32'd1234; b[1] = 32'd5678;
        for (int i = 0; i < 300 && !g; i++) begin #1; if (ready[1]) g = 1; else @(negedge clk); end
        @(posedge clk); #1 valid[1] = 1'b0;
        valid[2] = 1'b1; op[2] = 3'd5; a[2] = 32'd100; b[2] = 32'd7;
        for (int i = 1; i <= 11; i++) begin @(negedge clk); if (rsp_valid[1]) seen1 = 1; end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush_busy_before got=%b want=1", busy); end
        flush[1] = 1'b1;
        @(posedge clk); #1 flush[1] = 1'b0;
        @(negedge clk); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy_after got=%b want=0", busy); end
        tests++; if (ready !== 4'b0100) begin fails++; $display("FAIL flush_grant2 got=%b want=0100", ready); end
        @(posedge clk); #1 valid[2] = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (rsp_valid[1]) seen1 = 1;
            if (i == 5 || i == 20) flush[3] = 1'b1; else flush[3] = 1'b0;
            if (rsp_valid[2]) begin lat = i; d = rsp_data; break; end
        end
        flush[3] = 1'b0;
        tests++; if (lat != exp_lat(3'd5, 32'd100, 32'd7) || d !== model(3'd5, 32'd100, 32'd7)) begin
            fails++; $display("FAIL flush_req2 got=%h lat=%0d want=%h", d, lat, model(3'd5, 32'd100, 32'd7));
        end
        tests++; if (seen1) begin fails++; $display("FAIL flush_no_rsp1 got=1 want=0"); end
        // flush in the response cycle masks the pulse
        g = 0;
        @(negedge clk);
        valid[0] = 1'b1; op[0] = 3'd1; a[0] = 32'd99; b[0] = 32'd77;
        for (int i = 0; i < 300 && !g; i++) begin #1; if (ready[0]) g = 1; else @(negedge clk); end
        @(posedge clk); #1 valid[0] = 1'b0;
        repeat (35) @(negedge clk);
        flush[0] = 1'b1; #1;
        tests++; if (rsp_valid !== '0) begin fails++; $display("FAIL flush_resp_mask got=%b want=0", rsp_valid); end
        @(posedge clk); #1 flush[0] = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_resp_idle got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        bit g = 0, seen = 0;
        @(negedge clk);
        valid[2] = 1'b1; op[2] = 3'd0; a[2] = 32'd11; b[2] = 32'd13;
        for (int i = 0; i < 300 && !g; i++) begin #1; if (ready[2]) g = 1; else @(negedge clk); end
        @(posedge clk); #1 valid[2] = 1'b0;
        repeat (15) @(negedge clk);
        valid = '1;
        #2 rstn = 1'b0;
        #1;
        tests++; if (ready !== '0 || rsp_valid !== '0 || busy !== 1'b0 || rsp_data !== '0) begin
            fails++; $display("FAIL reset_mid_outputs got=%b/%b/%b/%h want=0", ready, rsp_valid, busy, rsp_data);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1; #1;
        tests++; if (ready !== 4'b0001) begin fails++; $display("FAIL reset_mid_first_grant got=%b want=0001", ready); end
        valid = '0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (rsp_valid !== '0) seen = 1; end
        tests++; if (seen) begin fails++; $display("FAIL reset_mid_no_rsp got=1 want=0"); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_round_robin();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
